// File: rtl/phy_arb_pkg.sv
// ---------------------------------------------------------------------------
// phy_arb_pkg : shared state encoding and default link words for phy_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package phy_arb_pkg;

   typedef enum logic [0:0] {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } arb_state_t;

   localparam logic [31:0] C_COM_WORD  = 32'hBCBC_BCBC;
   localparam logic [31:0] C_IDLE_WORD = 32'h7C7C_7C7C;

   // Counter width that stays legal for tiny parameter values.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/phy_arb_rr.sv
// ---------------------------------------------------------------------------
// phy_arb_rr : two-requester round-robin grant, evaluated on slot boundaries
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phy_arb_rr (
   input  logic clk_32f,
   input  logic reset,
   input  logic i_valid_0,
   input  logic i_valid_1,
   input  logic i_boundary,
   input  logic i_enable,
   output logic o_grant,
   output logic o_grant_vld
);

   logic r_rr_ptr;
   logic w_both;

   assign w_both      = i_valid_0 & i_valid_1;
   assign o_grant_vld = i_boundary & i_enable & (i_valid_0 | i_valid_1);
   assign o_grant     = w_both ? r_rr_ptr : i_valid_1;

   // A grant is always accepted (ready implies valid), so every grant is a transfer.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_rr_ptr <= 1'b0;
      end else if (o_grant_vld) begin
         r_rr_ptr <= ~r_rr_ptr;
      end
   end

endmodule

`default_nettype wire

// File: rtl/phy_arbiter.sv
// ---------------------------------------------------------------------------
// phy_arbiter : slot-based two-requester arbiter feeding a phy word stream.
// Optional per-requester grant counters with `define PHY_ARB_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phy_arbiter
   import phy_arb_pkg::*;
#(
   parameter int          WORD_CYCLES = 16,
   parameter int          SYNC_WORDS  = 4,
   parameter logic [31:0] COM_WORD    = C_COM_WORD,
   parameter logic [31:0] IDLE_WORD   = C_IDLE_WORD
) (
   input  logic        clk_32f,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] data_in_0,
   input  logic [31:0] data_in_1,
   input  logic        valid_in_0,
   input  logic        valid_in_1,
   output logic        ready_0,
   output logic        ready_1,
   output logic [31:0] data_out,
   output logic        valid_out,
   output logic        link_up
`ifdef PHY_ARB_STATS_EN
   ,
   output logic [15:0] grant_cnt_0,
   output logic [15:0] grant_cnt_1
`endif
);

   localparam int SLOT_W = cnt_width(WORD_CYCLES);
   localparam int SYNC_W = cnt_width(SYNC_WORDS);

   arb_state_t          r_state;
   logic [SLOT_W-1:0]   r_slot_cnt;
   logic [SYNC_W-1:0]   r_sync_cnt;
   logic [31:0]         r_data_out;
   logic                r_valid_out;
   logic                r_link_up;

   logic                w_boundary;
   logic                w_active_en;
   logic                w_grant;
   logic                w_grant_vld;
   logic [31:0]         w_grant_data;

   assign w_boundary  = (r_slot_cnt == SLOT_W'(WORD_CYCLES - 1));
   assign w_active_en = (r_state == ST_ACTIVE) & enable;

   phy_arb_rr u_rr (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .i_valid_0   (valid_in_0),
      .i_valid_1   (valid_in_1),
      .i_boundary  (w_boundary),
      .i_enable    (w_active_en),
      .o_grant     (w_grant),
      .o_grant_vld (w_grant_vld)
   );

   assign ready_0      = w_grant_vld & ~w_grant;
   assign ready_1      = w_grant_vld &  w_grant;
   assign w_grant_data = w_grant ? data_in_1 : data_in_0;

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_state     <= ST_SYNC;
         r_slot_cnt  <= '0;
         r_sync_cnt  <= '0;
         r_data_out  <= COM_WORD;
         r_valid_out <= 1'b1;
         r_link_up   <= 1'b0;
      end else begin
         r_slot_cnt <= w_boundary ? '0 : r_slot_cnt + SLOT_W'(1);
         if (w_boundary) begin
            case (r_state)
               ST_SYNC: begin
                  // The boundary closing the last COM slot opens the first ACTIVE slot.
                  if (r_sync_cnt == SYNC_W'(SYNC_WORDS - 1)) begin
                     r_state     <= ST_ACTIVE;
                     r_link_up   <= 1'b1;
                     r_data_out  <= IDLE_WORD;
                     r_valid_out <= 1'b0;
                  end else begin
                     r_sync_cnt  <= r_sync_cnt + SYNC_W'(1);
                     r_data_out  <= COM_WORD;
                     r_valid_out <= 1'b1;
                  end
               end
               ST_ACTIVE: begin
                  if (w_grant_vld) begin
                     r_data_out  <= w_grant_data;
                     r_valid_out <= 1'b1;
                  end else begin
                     r_data_out  <= IDLE_WORD;
                     r_valid_out <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_SYNC;
               end
            endcase
         end
      end
   end

   assign data_out  = r_data_out;
   assign valid_out = r_valid_out;
   assign link_up   = r_link_up;

`ifdef PHY_ARB_STATS_EN
   logic [15:0] r_grant_cnt_0;
   logic [15:0] r_grant_cnt_1;

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_grant_cnt_0 <= '0;
         r_grant_cnt_1 <= '0;
      end else begin
         if (ready_0 && (r_grant_cnt_0 != 16'hFFFF)) begin
            r_grant_cnt_0 <= r_grant_cnt_0 + 16'd1;
         end
         if (ready_1 && (r_grant_cnt_1 != 16'hFFFF)) begin
            r_grant_cnt_1 <= r_grant_cnt_1 + 16'd1;
         end
      end
   end

   assign grant_cnt_0 = r_grant_cnt_0;
   assign grant_cnt_1 = r_grant_cnt_1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phy_arbiter.sv
// ---------------------------------------------------------------------------
// tb_phy_arbiter : randomized scoreboard bench for phy_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_phy_arbiter;

   localparam int          WC   = 16;
   localparam int          SW   = 4;
   localparam logic [31:0] COM  = 32'hBCBC_BCBC;
   localparam logic [31:0] IDLE = 32'h7C7C_7C7C;

   logic        clk_32f = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] data_in_0 = '0;
   logic [31:0] data_in_1 = '0;
   logic        valid_in_0 = 1'b0;
   logic        valid_in_1 = 1'b0;
   logic        ready_0;
   logic        ready_1;
   logic [31:0] data_out;
   logic        valid_out;
   logic        link_up;
`ifdef PHY_ARB_STATS_EN
   logic [15:0] grant_cnt_0;
   logic [15:0] grant_cnt_1;
`endif

   phy_arbiter dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .enable     (enable),
      .data_in_0  (data_in_0),
      .data_in_1  (data_in_1),
      .valid_in_0 (valid_in_0),
      .valid_in_1 (valid_in_1),
      .ready_0    (ready_0),
      .ready_1    (ready_1),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .link_up    (link_up)
`ifdef PHY_ARB_STATS_EN
      ,
      .grant_cnt_0(grant_cnt_0),
      .grant_cnt_1(grant_cnt_1)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   typedef struct {
      logic [31:0] data;
      logic        valid;
      logic        link;
      logic [15:0] c0;
      logic [15:0] c1;
   } exp_t;

   exp_t       q_word[$];
   logic [1:0] q_rdy[$];
   int         vectors = 0;
   int         miscompares = 0;

   // Reference model: slot index since reset, pointer, pending requester words.
   int          m_slot;
   bit          m_rr;
   bit          has0, has1;
   logic [31:0] w0, w1;
   int          m_cnt0, m_cnt1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: expected entry missing at %0t", name, $time);
   endtask

   task automatic push_word(input logic [31:0] d, input logic v, input logic l);
      exp_t e;
      e.data  = d;
      e.valid = v;
      e.link  = l;
      e.c0    = 16'((m_cnt0 > 65535) ? 65535 : m_cnt0);
      e.c1    = 16'((m_cnt1 > 65535) ? 65535 : m_cnt1);
      q_word.push_back(e);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      valid_in_0 = 1'b0;
      valid_in_1 = 1'b0;
      m_slot = 0; m_rr = 1'b0; has0 = 1'b0; has1 = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0;
      q_word.delete();
      q_rdy.delete();
      push_word(COM, 1'b1, 1'b0);
      @(negedge clk_32f);
      reset = 1'b0;
   endtask

   task automatic drive_true();
      valid_in_0 = has0;
      valid_in_1 = has1;
      data_in_0  = w0;
      data_in_1  = w1;
   endtask

   task automatic boundary_model();
      logic [1:0] r;
      bit         g;
      r = 2'b00;
      if (m_slot < SW - 1) begin
         push_word(COM, 1'b1, 1'b0);
      end else if (m_slot == SW - 1) begin
         push_word(IDLE, 1'b0, 1'b1);
      end else if (enable && (has0 || has1)) begin
         g = (has0 && has1) ? m_rr : has1;
         m_rr = ~m_rr;
         if (g) begin
            r = 2'b10; has1 = 1'b0; m_cnt1++;
            push_word(w1, 1'b1, 1'b1);
         end else begin
            r = 2'b01; has0 = 1'b0; m_cnt0++;
            push_word(w0, 1'b1, 1'b1);
         end
      end else begin
         push_word(IDLE, 1'b0, 1'b1);
      end
      q_rdy.push_back(r);
      m_slot++;
   endtask

   // One full slot, entered at the negedge of its first cycle.
   task automatic run_slot(input int p0, input int p1, input bit en, input bit rst7, input bit fix0);
      int g;
      g = $urandom_range(1, WC - 3);
      for (int k = 0; k < WC; k++) begin
         if (k == 0) begin
            if (!has0 && ($urandom_range(0, 99) < p0)) begin
               has0 = 1'b1;
               w0   = fix0 ? 32'hA5A5_0001 : 32'($urandom);
            end
            if (!has1 && ($urandom_range(0, 99) < p1)) begin
               has1 = 1'b1;
               w1   = 32'($urandom);
            end
            enable = en;
            drive_true();
         end else if (k == g) begin
            valid_in_0 = 1'($urandom_range(0, 1));
            valid_in_1 = 1'($urandom_range(0, 1));
            data_in_0  = 32'($urandom);
            data_in_1  = 32'($urandom);
         end else if (k == g + 1) begin
            drive_true();
         end
         if (rst7 && k == 7) begin
            do_reset();
            return;
         end
         if (k == WC - 1) boundary_model();
         @(negedge clk_32f);
      end
   endtask

   initial begin : monitor
      int   c;
      exp_t e;
      logic [1:0] er;
      c = 0;
      e.data = COM; e.valid = 1'b1; e.link = 1'b0; e.c0 = '0; e.c1 = '0;
      forever begin
         @(negedge clk_32f);
         #1;
         if (reset) begin
            c = 0;
            continue;
         end
         if (c % WC == 0) begin
            if (q_word.size() == 0) begin
               fail_now("word_queue");
            end else begin
               e = q_word.pop_front();
               check("valid_out", 32'(valid_out), 32'(e.valid));
               check("link_up", 32'(link_up), 32'(e.link));
`ifdef PHY_ARB_STATS_EN
               check("grant_cnt_0", 32'(grant_cnt_0), 32'(e.c0));
               check("grant_cnt_1", 32'(grant_cnt_1), 32'(e.c1));
`endif
            end
         end
         check("data_out", data_out, e.data);
         if (c % WC == WC - 1) begin
            if (q_rdy.size() == 0) begin
               fail_now("ready_queue");
            end else begin
               er = q_rdy.pop_front();
               check("ready_0_boundary", 32'(ready_0), 32'(er[0]));
               check("ready_1_boundary", 32'(ready_1), 32'(er[1]));
            end
         end else begin
            check("ready_0_midslot", 32'(ready_0), 32'd0);
            check("ready_1_midslot", 32'(ready_1), 32'd0);
         end
         c++;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      w0 = '0;
      w1 = '0;
      @(negedge clk_32f);
      do_reset();
      for (int i = 0; i < 6; i++) run_slot(0, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) run_slot(100, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) run_slot(100, 100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) run_slot(100, 100, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) run_slot(100, 100, 1'b1, 1'b0, 1'b0);
      run_slot(100, 100, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) run_slot(0, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) run_slot(0, 100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         run_slot($urandom_range(0, 100), $urandom_range(0, 100),
                  ($urandom_range(0, 9) != 0), 1'b0, 1'b0);
      end
      #3;
      check("word_queue_drained", 32'(q_word.size()), 32'd0);
      check("ready_queue_drained", 32'(q_rdy.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
